// File: rtl/uart_pkg.sv
// Shared TX/RX state encodings, the minimum bit period and the parity helper for uart_xcvr.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int MIN_CLK_DIV = 4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Even-parity bit over a zero-extended word: total count of ones including this bit is even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO; head word is visible while valid, last popped word is held when empty.
// Latency: push visible on head the cycle after the write; overrun pulse one cycle after the refused push.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped and flagged.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] head_dat,
    output logic              head_vld,
    output logic [LW-1:0]     level,
    output logic              overrun
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              overrun_q, overrun_d;
    logic              empty, full, do_push, do_pop;

    // Accept/refuse decisions; pointers wrap naturally because the depth is a power of two.
    always_comb begin
        empty     = (level_q == '0);
        full      = (level_q == LW'(FIFO_DEPTH));
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        overrun_d = push && !do_push;
        wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d   = level_q + LW'(do_push) - LW'(do_pop);
        last_d    = do_pop ? mem_q[rd_ptr_q] : last_q;
    end

    // Control state; last_q keeps rx_data stable once the FIFO drains.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            last_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array; when full with a same-cycle pop the write lands in the slot being read out.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_vld = !empty;
    assign head_dat = empty ? last_q : mem_q[rd_ptr_q];
    assign level    = level_q;
    assign overrun  = overrun_q;

endmodule

// File: rtl/uart_xcvr.sv
// UART transceiver: LSB-first 8N1 TX, mid-bit sampled RX into a show-ahead FIFO; UART_PARITY_EN adds even parity.
// Latency: TX start bit one cycle after tx_start; RX byte pushed one cycle after the stop-bit mid-sample.
// Backpressure: tx_start ignored while tx_busy; RX bytes arriving into a full FIFO are dropped with rx_overrun.
module uart_xcvr #(
    parameter int DATA_W     = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_busy,
    output logic              ser_tx,
    input  logic              ser_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [LW-1:0]     rx_level,
    output logic              rx_overrun,
    output logic              frame_err,
    output logic              parity_err
);
    import uart_pkg::*;

    localparam int BW = $clog2(DATA_W);

    logic [DIV_W-1:0] div_safe;
    assign div_safe = (clk_div < DIV_W'(MIN_CLK_DIV)) ? DIV_W'(MIN_CLK_DIV) : clk_div;

    tx_state_t         tx_state_q, tx_state_d;
    logic [DIV_W-1:0]  tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic              ser_tx_q, ser_tx_d;
    logic              tx_bit_end;

    // TX sequencing; the shifter rotates so the original word is back in place for the parity bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_bit_end = (tx_cnt_q == tx_div_q - 1'b1);
        if (tx_state_q == TX_IDLE) begin
            if (tx_start) begin
                tx_state_d = TX_START;
                tx_shift_d = tx_data;
                tx_div_d   = div_safe;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
            end
        end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
            if (tx_bit_end) begin
                tx_cnt_d = '0;
                case (tx_state_q)
                    TX_START: tx_state_d = TX_DATA;
                    TX_DATA: begin
                        tx_shift_d = {tx_shift_q[0], tx_shift_q[DATA_W-1:1]};
                        tx_bit_d   = tx_bit_q + 1'b1;
                        if (tx_bit_q == BW'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                            tx_state_d = TX_PARITY;
`else
                            tx_state_d = TX_STOP;
`endif
                        end
                    end
                    TX_PARITY: tx_state_d = TX_STOP;
                    default:   tx_state_d = TX_IDLE;
                endcase
            end
        end
        // Line level for the bit being entered, registered so ser_tx is glitch-free.
        case (tx_state_d)
            TX_START:  ser_tx_d = 1'b0;
            TX_DATA:   ser_tx_d = tx_shift_d[0];
            TX_PARITY: ser_tx_d = even_parity(8'(tx_shift_d));
            default:   ser_tx_d = 1'b1;
        endcase
    end

    // TX registers; reset forces the line idle high at once.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            tx_state_q <= TX_IDLE;
            tx_div_q   <= '0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            ser_tx_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            ser_tx_q   <= ser_tx_d;
        end
    end

    assign ser_tx  = ser_tx_q;
    assign tx_busy = (tx_state_q != TX_IDLE);

    logic rx_s1_q, rx_s2_q, rx_prev_q;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle-high reset.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= ser_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    rx_state_t         rx_state_q, rx_state_d;
    logic [DIV_W-1:0]  rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]     rx_bit_q, rx_bit_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic              push_q, push_d, frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    logic              rx_mid;

    // RX sequencing: half a bit to the start-bit centre, then whole bit periods between samples.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_div_d     = rx_div_q;
        rx_cnt_d     = rx_cnt_q + 1'b1;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        push_d       = 1'b0;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        rx_mid       = (rx_cnt_q == rx_div_q - 1'b1);
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_div_d   = div_safe;
                    rx_cnt_d   = DIV_W'(1);
                end
            end
            RX_START: begin
                if (rx_cnt_q == (rx_div_q >> 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_mid) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_W-1:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == BW'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end
                end
            end
            RX_PARITY: begin
                if (rx_mid) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q != even_parity(8'(rx_shift_q))) begin
`ifdef UART_PARITY_EN
                        parity_err_d = 1'b1;
`endif
                        rx_state_d = RX_WAIT_HIGH;
                    end else begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (rx_mid) begin
                    if (!rx_s2_q) begin
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_WAIT_HIGH;
                    end else begin
                        push_d     = 1'b1;
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            default: begin
                if (rx_s2_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
        endcase
    end

    // RX registers; reset drops any frame in progress before it can be pushed.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            rx_state_q   <= RX_IDLE;
            rx_div_q     <= '0;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_div_q     <= rx_div_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            push_q       <= push_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

    uart_rx_fifo #(
        .DATA_W    (DATA_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_rx_fifo (
        .clock   (clock),
        .resetb  (resetb),
        .push    (push_q),
        .push_dat(rx_shift_q),
        .pop     (rx_ready),
        .head_dat(rx_data),
        .head_vld(rx_valid),
        .level   (rx_level),
        .overrun (rx_overrun)
    );

endmodule

// File: tb/tb_uart_xcvr.sv
// Directed bench for uart_xcvr: TX waveform, loopback, overrun, frame/glitch errors, parity, mid-frame reset.
// Latency: not applicable.
// Backpressure: rx_ready driven explicitly by the bench.
module tb_uart_xcvr;

    localparam int DATA_W     = 8;
    localparam int DIV_W      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH + 1);
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic              clock   = 1'b0;
    logic              resetb  = 1'b0;
    logic [DIV_W-1:0]  clk_div = 16'd16;
    logic              tx_start = 1'b0;
    logic [DATA_W-1:0] tx_data  = '0;
    logic              rx_ready = 1'b0;
    logic              lb_en    = 1'b0;
    logic              rx_drv   = 1'b1;
    logic              ser_rx_w;
    logic              tx_busy, ser_tx, rx_valid, rx_overrun, frame_err, parity_err;
    logic [DATA_W-1:0] rx_data;
    logic [LW-1:0]     rx_level;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int pe_cnt   = 0;
    int ov_cnt   = 0;

    assign ser_rx_w = lb_en ? ser_tx : rx_drv;

    uart_xcvr #(
        .DATA_W    (DATA_W),
        .DIV_W     (DIV_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock     (clock),
        .resetb    (resetb),
        .clk_div   (clk_div),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .ser_tx    (ser_tx),
        .ser_rx    (ser_rx_w),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_level  (rx_level),
        .rx_overrun(rx_overrun),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clock = ~clock;

    // Error pulse counters, sampled away from the active edge.
    always @(negedge clock) begin
        if (resetb) begin
            if (frame_err)  fe_cnt++;
            if (parity_err) pe_cnt++;
            if (rx_overrun) ov_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line bits in time order: start, data LSB first, parity slot, stop (stop moves down without parity).
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] f;
        f = {stop, par, d, 1'b0};
`ifndef UART_PARITY_EN
        f[9] = stop;
`endif
        return f;
    endfunction

    task automatic tx_frame_check(input logic [7:0] d, input bit poke);
        logic [10:0] frm;
        int div;
        frm = frame_bits(d, ^d, 1'b1);
        div = int'(clk_div);
        @(negedge clock);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        for (int i = 0; i < NBITS * div; i++) begin
            if (poke && i == 40) begin
                tx_start = 1'b1;
                tx_data  = ~d;
            end else begin
                tx_start = 1'b0;
            end
            check("tx_bit", ser_tx, frm[i / div]);
            check("tx_busy", tx_busy, 1);
            @(negedge clock);
        end
        tx_start = 1'b0;
        check("tx_busy_fall", tx_busy, 0);
        check("tx_idle_line", ser_tx, 1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clock);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        while (tx_busy && t < 3000) begin
            @(negedge clock);
            t++;
        end
        check("send_done", tx_busy, 0);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] frm;
        frm = frame_bits(d, par, stop);
        @(negedge clock);
        for (int i = 0; i < NBITS; i++) begin
            rx_drv = frm[i];
            repeat (int'(clk_div)) @(negedge clock);
        end
        rx_drv = 1'b1;
    endtask

    task automatic wait_level(input int n);
        int t;
        t = 0;
        while (rx_level != LW'(n) && t < 4000) begin
            @(negedge clock);
            t++;
        end
        check("wait_level", rx_level, n);
    endtask

    task automatic pop_expect(input logic [7:0] d);
        check("pop_valid", rx_valid, 1);
        check("pop_data", rx_data, d);
        @(negedge clock);
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clock);
        check("rst_ser_tx", ser_tx, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_errs", {rx_overrun, frame_err, parity_err}, 0);
        resetb = 1'b1;
        repeat (2) @(negedge clock);

        // TX waveform for 8'h3D with an ignored tx_start mid-frame
        tx_frame_check(8'h3D, 1'b1);
        repeat (4) @(negedge clock);
        check("tx_no_restart", tx_busy, 0);

        // Loopback of two bytes, then pops and hold-on-empty
        lb_en = 1'b1;
        send_byte(8'h3D);
        send_byte(8'h0F);
        wait_level(2);
        check("lb_head", rx_data, 8'h3D);
        pop_expect(8'h3D);
        check("lb_level1", rx_level, 1);
        pop_expect(8'h0F);
        check("lb_empty_valid", rx_valid, 0);
        check("lb_empty_level", rx_level, 0);
        repeat (5) @(negedge clock);
        check("lb_hold_data", rx_data, 8'h0F);

        // Overrun: five frames into a four-entry FIFO
        for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i));
        repeat (40) @(negedge clock);
        check("ovr_level", rx_level, 4);
        check("ovr_pulses", ov_cnt, 1);
        for (int i = 0; i < 4; i++) pop_expect(8'hA1 + 8'(i));
        check("ovr_drained", rx_level, 0);

        // Frame error, then a good frame to prove re-arming
        lb_en  = 1'b0;
        rx_drv = 1'b1;
        repeat (10) @(negedge clock);
        drive_frame(8'h55, ^8'h55, 1'b0);
        repeat (40) @(negedge clock);
        check("fe_pulse", fe_cnt, 1);
        check("fe_level", rx_level, 0);
        drive_frame(8'h55, ^8'h55, 1'b1);
        wait_level(1);
        pop_expect(8'h55);

        // Three-cycle low glitch is rejected
        @(negedge clock);
        rx_drv = 1'b0;
        repeat (3) @(negedge clock);
        rx_drv = 1'b1;
        repeat (60) @(negedge clock);
        check("glitch_level", rx_level, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_no_fe", fe_cnt, 1);

`ifdef UART_PARITY_EN
        // Parity: wrong bit drops the byte, right bit stores it
        clk_div = 16'd8;
        drive_frame(8'h01, 1'b0, 1'b1);
        repeat (30) @(negedge clock);
        check("par_err_pulse", pe_cnt, 1);
        check("par_err_level", rx_level, 0);
        drive_frame(8'h01, 1'b1, 1'b1);
        wait_level(1);
        pop_expect(8'h01);
        check("par_ok_no_err", pe_cnt, 1);
        clk_div = 16'd16;
`endif

        // Reset during TX data bit 3 with a byte already queued
        lb_en = 1'b1;
        send_byte(8'h11);
        wait_level(1);
        @(negedge clock);
        tx_data  = 8'hC3;
        tx_start = 1'b1;
        @(negedge clock);
        tx_start = 1'b0;
        repeat (68) @(negedge clock);
        check("pre_rst_bit3", ser_tx, 0);
        resetb = 1'b0;
        #1;
        check("mid_rst_ser_tx", ser_tx, 1);
        check("mid_rst_busy", tx_busy, 0);
        check("mid_rst_level", rx_level, 0);
        check("mid_rst_valid", rx_valid, 0);
        repeat (3) @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        tx_frame_check(8'h5A, 1'b0);
        wait_level(1);
        pop_expect(8'h5A);
        repeat (40) @(negedge clock);
        check("post_rst_level", rx_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
